// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for one memory bus: one latched transaction per grant.
// Latency: request->strobe 1 cycle, ready->m*Ready 0 cycles; masters wait for m*Ready.
// Optional bus timeout when MEM_ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
  parameter int ADDRESS_SIZE   = 16,
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      m0Strobe,
  input  logic [ADDRESS_SIZE-1:0]   m0Address,
  input  logic [DATA_SIZE-1:0]      m0DataWrite,
  input  logic [DATA_SIZE/8-1:0]    m0WriteEnable,
  output logic                      m0Ready,
  input  logic                      m1Strobe,
  input  logic [ADDRESS_SIZE-1:0]   m1Address,
  input  logic [DATA_SIZE-1:0]      m1DataWrite,
  input  logic [DATA_SIZE/8-1:0]    m1WriteEnable,
  output logic                      m1Ready,
  output logic                      mError,
  output logic [DATA_SIZE-1:0]      mDataRead,
  output logic [ADDRESS_SIZE-1:0]   address,
  output logic [DATA_SIZE-1:0]      dataWrite,
  output logic [DATA_SIZE/8-1:0]    writeEnable,
  output logic                      strobe,
  input  logic                      ready,
  input  logic [DATA_SIZE-1:0]      dataRead,
  output logic                      grant
);

  localparam int WE_SIZE = DATA_SIZE / 8;

  if (DATA_SIZE % 8 != 0) begin : g_bad_data_size
    $error("mem_bus_arbiter: DATA_SIZE must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state_q, state_d;
  logic                     grant_q, grant_d;
  logic                     strobe_q, strobe_d;
  logic [ADDRESS_SIZE-1:0]  addr_q, addr_d;
  logic [DATA_SIZE-1:0]     wdat_q, wdat_d;
  logic [WE_SIZE-1:0]       we_q, we_d;
  logic                     win;
  logic                     timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero outside BUSY, so every transaction starts counting from 0.
  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY && !ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (state_q == BUSY) && (cnt_q == CNT_LAST) && !ready;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    strobe_d = strobe_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    we_d     = we_q;
    m0Ready  = 1'b0;
    m1Ready  = 1'b0;
    mError   = 1'b0;
    // On a tie the master that did not win last time goes next.
    win      = (m0Strobe && m1Strobe) ? ~grant_q : m1Strobe;

    case (state_q)
      IDLE: begin
        if (m0Strobe || m1Strobe) begin
          grant_d  = win;
          strobe_d = 1'b1;
          addr_d   = win ? m1Address     : m0Address;
          wdat_d   = win ? m1DataWrite   : m0DataWrite;
          we_d     = win ? m1WriteEnable : m0WriteEnable;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (ready || timeout) begin
          m0Ready  = ~grant_q;
          m1Ready  = grant_q;
          mError   = timeout;
          strobe_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        strobe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b1;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      we_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      we_q     <= we_d;
    end
  end

  assign address     = addr_q;
  assign dataWrite   = wdat_q;
  assign writeEnable = we_q;
  assign strobe      = strobe_q;
  assign grant       = grant_q;
  assign mDataRead   = dataRead;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic against a round-robin model.
module tb_mem_bus_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          m0Strobe, m1Strobe;
  logic [AW-1:0] m0Address, m1Address;
  logic [DW-1:0] m0DataWrite, m1DataWrite;
  logic [BW-1:0] m0WriteEnable, m1WriteEnable;
  logic          m0Ready, m1Ready, mError;
  logic [DW-1:0] mDataRead;
  logic [AW-1:0] address;
  logic [DW-1:0] dataWrite;
  logic [BW-1:0] writeEnable;
  logic          strobe;
  logic          ready;
  logic [DW-1:0] dataRead;
  logic          grant;

  int checks = 0;
  int failures = 0;
  int last_g;

  mem_bus_arbiter #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .m0Strobe(m0Strobe), .m0Address(m0Address), .m0DataWrite(m0DataWrite),
    .m0WriteEnable(m0WriteEnable), .m0Ready(m0Ready),
    .m1Strobe(m1Strobe), .m1Address(m1Address), .m1DataWrite(m1DataWrite),
    .m1WriteEnable(m1WriteEnable), .m1Ready(m1Ready),
    .mError(mError), .mDataRead(mDataRead),
    .address(address), .dataWrite(dataWrite), .writeEnable(writeEnable),
    .strobe(strobe), .ready(ready), .dataRead(dataRead), .grant(grant)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_fields();
    m0Address = AW'($urandom); m0DataWrite = $urandom; m0WriteEnable = BW'($urandom);
    m1Address = AW'($urandom); m1DataWrite = $urandom; m1WriteEnable = BW'($urandom);
  endtask

  // Round-robin rule: a lone requester wins; on a tie the one not granted last wins.
  function automatic int pick(bit s0, bit s1, int last);
    if (s0 && s1) return 1 - last;
    return s1 ? 1 : 0;
  endfunction

  task automatic test_reset();
    reset = 1'b0; ready = 1'b0; dataRead = '0;
    m0Strobe = 1'b1; m1Strobe = 1'b1;
    rand_fields();
    tick(); tick();
    checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL rst_strobe got=%0h exp=0", strobe); end
    checks++; if (address !== '0) begin failures++; $display("FAIL rst_address got=%0h exp=0", address); end
    checks++; if (writeEnable !== '0 || dataWrite !== '0) begin failures++; $display("FAIL rst_wdata got=%0h/%0h exp=0/0", writeEnable, dataWrite); end
    checks++; if (grant !== 1'b1) begin failures++; $display("FAIL rst_grant got=%0h exp=1", grant); end
    checks++; if (m0Ready !== 1'b0 || m1Ready !== 1'b0 || mError !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b%b%b exp=000", m0Ready, m1Ready, mError); end
    reset = 1'b1;
    last_g = 1;
    tick();
    checks++; if (grant !== 1'b0) begin failures++; $display("FAIL rst_first_grant got=%0h exp=0", grant); end
    checks++; if (address !== m0Address) begin failures++; $display("FAIL rst_first_addr got=%0h exp=%0h", address, m0Address); end
    checks++; if (strobe !== 1'b1) begin failures++; $display("FAIL rst_first_strobe got=%0h exp=1", strobe); end
    dataRead = $urandom; ready = 1'b1; #1;
    checks++; if (m0Ready !== 1'b1 || m1Ready !== 1'b0) begin failures++; $display("FAIL rst_first_ready got=%b%b exp=10", m0Ready, m1Ready); end
    tick();
    m0Strobe = 1'b0; m1Strobe = 1'b0; ready = 1'b0;
    checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL rst_first_strobe_fall got=%0h exp=0", strobe); end
    last_g = 0;
  endtask

  task automatic test_single_read();
    m0Strobe = 1'b0; m1Strobe = 1'b1; m1Address = 16'h1234; m1WriteEnable = '0;
    tick();
    checks++; if (strobe !== 1'b1 || grant !== 1'b1 || address !== 16'h1234 || writeEnable !== '0) begin
      failures++; $display("FAIL rd_issue got=s%0h g%0h a%0h we%0h exp=s1 g1 a1234 we0", strobe, grant, address, writeEnable); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (m0Ready !== 1'b0 || m1Ready !== 1'b0) begin failures++; $display("FAIL rd_wait%0d got=%b%b exp=00", c, m0Ready, m1Ready); end
      tick();
    end
    dataRead = 32'hDEADBEEF; ready = 1'b1; #1;
    checks++; if (m1Ready !== 1'b1 || m0Ready !== 1'b0 || mError !== 1'b0) begin failures++; $display("FAIL rd_ready got=%b%b%b exp=010", m0Ready, m1Ready, mError); end
    checks++; if (mDataRead !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%0h exp=deadbeef", mDataRead); end
    tick();
    m1Strobe = 1'b0; ready = 1'b0; #1;
    checks++; if (strobe !== 1'b0 || m1Ready !== 1'b0) begin failures++; $display("FAIL rd_end got=s%0h r%0h exp=s0 r0", strobe, m1Ready); end
    last_g = 1;
  endtask

  task automatic test_withdrawal();
    m0Strobe = 1'b1; m0Address = 16'h0040; m0WriteEnable = 4'hF; m0DataWrite = $urandom;
    tick();
    tick();
    m0Strobe = 1'b0; m0Address = AW'($urandom);
    for (int c = 0; c < 2; c++) begin
      checks++; if (address !== 16'h0040 || strobe !== 1'b1 || writeEnable !== 4'hF) begin
        failures++; $display("FAIL wd_hold%0d got=a%0h s%0h we%0h exp=a40 s1 weF", c, address, strobe, writeEnable); end
      checks++; if (m0Ready !== 1'b0) begin failures++; $display("FAIL wd_early%0d got=%0h exp=0", c, m0Ready); end
      tick();
    end
    ready = 1'b1; #1;
    checks++; if (m0Ready !== 1'b1 || m1Ready !== 1'b0) begin failures++; $display("FAIL wd_ready got=%b%b exp=10", m0Ready, m1Ready); end
    tick();
    ready = 1'b0;
    checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL wd_end got=%0h exp=0", strobe); end
    last_g = 0;
  endtask

  task automatic test_reset_mid();
    m0Strobe = 1'b1; rand_fields();
    tick();
    checks++; if (grant !== 1'b0 || strobe !== 1'b1) begin failures++; $display("FAIL rm_issue got=g%0h s%0h exp=g0 s1", grant, strobe); end
    tick();
    reset = 1'b0; m0Strobe = 1'b0;
    tick();
    checks++; if (strobe !== 1'b0 || address !== '0 || grant !== 1'b1) begin
      failures++; $display("FAIL rm_state got=s%0h a%0h g%0h exp=s0 a0 g1", strobe, address, grant); end
    ready = 1'b1; #1;
    checks++; if (m0Ready !== 1'b0 || m1Ready !== 1'b0) begin failures++; $display("FAIL rm_no_pulse got=%b%b exp=00", m0Ready, m1Ready); end
    reset = 1'b1;
    tick(); #1;
    checks++; if (m0Ready !== 1'b0 || m1Ready !== 1'b0 || strobe !== 1'b0) begin
      failures++; $display("FAIL rm_idle_ready got=%b%b s%0h exp=00 s0", m0Ready, m1Ready, strobe); end
    ready = 1'b0;
    last_g = 1;
  endtask

  task automatic test_contention();
    int exp_g [4] = '{0, 1, 0, 1};
    m0Strobe = 1'b1; m1Strobe = 1'b1;
    for (int t = 0; t < 4; t++) begin
      rand_fields();
      tick();
      checks++; if (grant !== exp_g[t][0] || strobe !== 1'b1) begin failures++; $display("FAIL ct_grant%0d got=g%0h s%0h exp=g%0h s1", t, grant, strobe, exp_g[t]); end
      checks++; if (dataWrite !== (exp_g[t] == 1 ? m1DataWrite : m0DataWrite) ||
                    writeEnable !== (exp_g[t] == 1 ? m1WriteEnable : m0WriteEnable)) begin
        failures++; $display("FAIL ct_fields%0d got=%0h/%0h", t, dataWrite, writeEnable); end
      dataRead = $urandom; ready = 1'b1; #1;
      checks++; if (m0Ready !== (exp_g[t] == 0) || m1Ready !== (exp_g[t] == 1)) begin
        failures++; $display("FAIL ct_ready%0d got=%b%b exp_grant=%0d", t, m0Ready, m1Ready, exp_g[t]); end
      tick();
      ready = 1'b0;
      checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL ct_gap%0d got=%0h exp=0", t, strobe); end
      last_g = exp_g[t];
    end
    m0Strobe = 1'b0; m1Strobe = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      bit s0, s1;
      int w, lat;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed, rd;
      logic [BW-1:0] ee;
      do begin
        s0 = 1'($urandom_range(0, 1));
        s1 = 1'($urandom_range(0, 1));
      end while (!(s0 || s1));
      rand_fields();
      m0Strobe = s0; m1Strobe = s1;
      w  = pick(s0, s1, last_g);
      ea = (w == 1) ? m1Address : m0Address;
      ed = (w == 1) ? m1DataWrite : m0DataWrite;
      ee = (w == 1) ? m1WriteEnable : m0WriteEnable;
      lat = $urandom_range(0, 2);
      tick();
      checks++; if (strobe !== 1'b1 || grant !== w[0]) begin failures++; $display("FAIL rnd_grant%0d got=s%0h g%0h exp=s1 g%0h", t, strobe, grant, w); end
      checks++; if (address !== ea || dataWrite !== ed || writeEnable !== ee) begin
        failures++; $display("FAIL rnd_fields%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", t, address, dataWrite, writeEnable, ea, ed, ee); end
      for (int c = 0; c < lat; c++) begin
        // The losing master may change its fields freely; the latched request must not move.
        if (w == 1) begin m0Address = AW'($urandom); m0DataWrite = $urandom; end
        else begin m1Address = AW'($urandom); m1DataWrite = $urandom; end
        #1;
        checks++; if (m0Ready !== 1'b0 || m1Ready !== 1'b0) begin failures++; $display("FAIL rnd_early%0d got=%b%b exp=00", t, m0Ready, m1Ready); end
        tick();
        checks++; if (address !== ea || dataWrite !== ed || strobe !== 1'b1) begin
          failures++; $display("FAIL rnd_hold%0d got=%0h/%0h/%0h exp=%0h/%0h/1", t, address, dataWrite, strobe, ea, ed); end
      end
      rd = $urandom; dataRead = rd; ready = 1'b1; #1;
      checks++; if (m0Ready !== (w == 0) || m1Ready !== (w == 1) || mError !== 1'b0) begin
        failures++; $display("FAIL rnd_ready%0d got=%b%b%b exp_grant=%0d", t, m0Ready, m1Ready, mError, w); end
      checks++; if (mDataRead !== rd) begin failures++; $display("FAIL rnd_data%0d got=%0h exp=%0h", t, mDataRead, rd); end
      tick();
      ready = 1'b0;
      checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL rnd_gap%0d got=%0h exp=0", t, strobe); end
      last_g = w;
    end
    m0Strobe = 1'b0; m1Strobe = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int run = 0; run < 2; run++) begin
      m0Strobe = (run == 0); m1Strobe = (run == 1);
      tick();
      for (int c = 1; c < TO; c++) begin
        checks++; if (m0Ready !== 1'b0 || m1Ready !== 1'b0 || mError !== 1'b0) begin
          failures++; $display("FAIL to_wait%0d_%0d got=%b%b%b exp=000", run, c, m0Ready, m1Ready, mError); end
        tick();
      end
      ready = (run == 1); dataRead = $urandom; #1;
      checks++; if (m0Ready !== (run == 0) || m1Ready !== (run == 1)) begin
        failures++; $display("FAIL to_ready%0d got=%b%b", run, m0Ready, m1Ready); end
      checks++; if (mError !== (run == 0)) begin failures++; $display("FAIL to_error%0d got=%0h exp=%0h", run, mError, run == 0); end
      tick();
      m0Strobe = 1'b0; m1Strobe = 1'b0; ready = 1'b0; #1;
      checks++; if (strobe !== 1'b0 || mError !== 1'b0) begin failures++; $display("FAIL to_end%0d got=s%0h e%0h exp=s0 e0", run, strobe, mError); end
      last_g = run;
    end
`else
    m0Strobe = 1'b1;
    tick();
    for (int c = 0; c < 3 * TO; c++) begin
      checks++; if (m0Ready !== 1'b0 || mError !== 1'b0 || strobe !== 1'b1) begin
        failures++; $display("FAIL nto_wait%0d got=r%0h e%0h s%0h exp=r0 e0 s1", c, m0Ready, mError, strobe); end
      tick();
    end
    ready = 1'b1; #1;
    checks++; if (m0Ready !== 1'b1 || mError !== 1'b0) begin failures++; $display("FAIL nto_ready got=r%0h e%0h exp=r1 e0", m0Ready, mError); end
    tick();
    m0Strobe = 1'b0; ready = 1'b0;
    last_g = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_withdrawal();
    test_reset_mid();
    test_contention();
    test_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter sharing the single memory bus between the RISC-V core and a second requester (debug/loader port). Each master presents a strobe/ready request; the arbiter grants one at a time with round-robin fairness, latches the winner's address, data and write enables, and runs exactly one memory transaction per grant. It sits between the masters and the memory-side bus (`address`, `dataWrite`, `writeEnable`, `strobe`, `ready`, `dataRead`).

## Interface
- `ADDRESS_SIZE`, 16: address width in bits.
- `DATA_SIZE`, 32: data width in bits; multiple of 8.
- `TIMEOUT_CYCLES`, 64: bus-timeout limit, ≥2; used only with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `m0Strobe`, `m1Strobe`  in  1 each  request from master 0 (CPU) / master 1.
- `m0Address`, `m1Address`  in  ADDRESS_SIZE  request address.
- `m0DataWrite`, `m1DataWrite`  in  DATA_SIZE  write data.
- `m0WriteEnable`, `m1WriteEnable`  in  DATA_SIZE/8  byte-lane write enables; all-zero means read.
- `m0Ready`, `m1Ready`  out  1  one-cycle completion pulse to the granted master.
- `mError`  out  1  qualifies the current `m*Ready` pulse as a timeout abort.
- `mDataRead`  out  DATA_SIZE  read data, shared by both masters; valid only with that master's `m*Ready`.
- `address`  out  ADDRESS_SIZE  memory-side address.
- `dataWrite`  out  DATA_SIZE  memory-side write data.
- `writeEnable`  out  DATA_SIZE/8  memory-side byte write enables.
- `strobe`  out  1  memory-side transaction request.
- `ready`  in  1  memory-side completion.
- `dataRead`  in  DATA_SIZE  memory-side read data.
- `grant`  out  1  index of the currently/last granted master (debug visibility).

## Operation
- States: IDLE, BUSY.
- IDLE: if any `m*Strobe` is high, pick the winner. If only one requests, it wins. If both request, the master not granted last wins.
  - On the winning edge, latch the winner's address, data and enables into the output registers.
  - Set `strobe`=1, set `grant`, and go to BUSY.
- BUSY: hold all memory-side outputs constant. When `ready`=1:
  - pass `dataRead` combinationally to `mDataRead`;
  - drive the granted `m*Ready`=1 for that cycle;
  - on the next edge clear `strobe` and return to IDLE.
- A master must hold its strobe and request fields until its ready pulse. If a master drops its strobe while BUSY, that is a protocol violation. The arbiter still completes the latched transaction, and the ready pulse is issued anyway.
- The non-granted master's ready output stays 0 throughout.
- `mError` is 0 except on a timeout abort (see Configuration).
- Reset (`reset`=0 at an edge), including mid-transaction:
  - state = IDLE, `strobe`=0, `address`/`dataWrite`/`writeEnable`=0;
  - `grant`=1, so master 0 wins the first tie;
  - `m*Ready`=0, `mError`=0;
  - the aborted transaction gets no ready pulse.

## Timing
- Request to `strobe`: 1 cycle (request sampled in IDLE at edge N; `strobe`=1 after edge N).
- `ready` to `m*Ready`: 0 cycles (combinational).
- After a `ready` cycle, `strobe` is low for exactly one cycle (the IDLE re-arbitration cycle) before the next transaction. Back-to-back throughput is one transaction per 2 cycles when memory answers in the first BUSY cycle.
- `ready` arriving while in IDLE is ignored.
- Continuous contention alternates grants M0, M1, M0, …

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - a cycle counter clears on entry to BUSY and increments each BUSY cycle without `ready`;
  - in the cycle where the count equals `TIMEOUT_CYCLES-1` and `ready`=0, the arbiter drives the granted `m*Ready`=1 and `mError`=1, with `mDataRead` = `dataRead` (don't-care);
  - on the next edge `strobe` is cleared and the state returns to IDLE;
  - if `ready`=1 in that same cycle, it is a normal completion with `mError`=0.
- Not defined: no counter. BUSY waits on `ready` indefinitely, and `mError` is constant 0.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, with both strobes high -> `strobe`=0, `address`=0, `grant`=1, both `m*Ready`=0. Release reset -> M0 is granted first (`grant`=0, `address`=`m0Address`).
- Single read: M1 reads 0x1234; memory returns `ready` 3 cycles after `strobe` with `dataRead`=0xDEADBEEF -> `m1Ready` pulses for 1 cycle with `mDataRead`=0xDEADBEEF; `strobe` falls on the next edge; `m0Ready` stays 0.
- Contention: both masters hold strobes for 4 transactions, with memory answering immediately -> grant sequence 0,1,0,1; `strobe` pattern 1,0,1,0,…; `writeEnable`/`dataWrite` match the granted master.
- Withdrawal: M0 write to 0x0040 with enables 0xF; M0 drops its strobe in the second BUSY cycle -> `address` stays 0x0040 and `strobe` stays 1 until `ready`, then `m0Ready` pulses.
- Reset mid-transaction: assert `reset`=0 while BUSY, before `ready` -> next edge `strobe`=0, no `m*Ready` pulse, state IDLE.
- Timeout (with `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): `ready` held 0 -> `m*Ready`=1 and `mError`=1 in the 4th BUSY cycle, `strobe`=0 after it. A repeat run with `ready`=1 in the 4th cycle gives `mError`=0.
